// File: rtl/md_if.sv
// E-stage bundle between the pipeline and the multiply/divide unit.
// The pipeline side drives operands and op codes; the md unit returns status and HI/LO.
interface md_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       e_md_op;
    logic             e_valid;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             d_is_md;
    logic             busy;
    logic             stall_d;
    logic [WIDTH-1:0] md_rdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output e_md_op, e_valid, rs_val, rt_val, d_is_md,
        input  busy, stall_d, md_rdata, hi, lo
    );

    modport slave (
        input  e_md_op, e_valid, rs_val, rt_val, d_is_md,
        output busy, stall_d, md_rdata, hi, lo
    );
endinterface

// File: rtl/md_sequencer.sv
// Multiply/divide unit with HI/LO for the E stage: results are computed at acceptance,
// held as pending, and committed after a fixed busy latency counted down by an IDLE/RUN FSM.
module md_sequencer #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset_n,
    md_if.slave  md
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   pend_hi_q;
    logic [WIDTH-1:0]   pend_lo_q;
    logic               pend_we_q;

    logic               busy;
    logic               start;
    logic               is_mult;
    logic [CNT_W-1:0]   start_cnt;

    logic [2*WIDTH-1:0] prod;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   div_den;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_we;

    assign busy      = (state_q == S_RUN);
    assign start     = md.e_valid && (md.e_md_op != 4'd0) && (md.e_md_op <= OP_DIVU);
    assign is_mult   = (md.e_md_op == OP_MULT) || (md.e_md_op == OP_MULTU);
    assign start_cnt = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

    // Signed divide works on magnitudes so that MIN / -1 wraps to MIN with a zero remainder.
    // NOTE: every signal driven here gets a value on every path first, otherwise a latch is inferred.
    always_comb begin
        prod    = '0;
        a_neg   = 1'b0;
        b_neg   = 1'b0;
        a_mag   = md.rs_val;
        b_mag   = md.rt_val;
        div_den = ONE;
        q_mag   = '0;
        r_mag   = '0;
        res_hi  = '0;
        res_lo  = '0;
        res_we  = 1'b0;

        if (md.e_md_op == OP_MULT) begin
            prod = {{WIDTH{md.rs_val[WIDTH-1]}}, md.rs_val} *
                   {{WIDTH{md.rt_val[WIDTH-1]}}, md.rt_val};
        end else begin
            prod = {{WIDTH{1'b0}}, md.rs_val} * {{WIDTH{1'b0}}, md.rt_val};
        end

        if (md.e_md_op == OP_DIV) begin
            a_neg = md.rs_val[WIDTH-1];
            b_neg = md.rt_val[WIDTH-1];
        end
        if (a_neg) a_mag = '0 - md.rs_val;
        if (b_neg) b_mag = '0 - md.rt_val;
        if (b_mag != '0) div_den = b_mag;
        q_mag = a_mag / div_den;
        r_mag = a_mag % div_den;

        case (md.e_md_op)
            OP_MULT, OP_MULTU: begin
                res_hi = prod[2*WIDTH-1:WIDTH];
                res_lo = prod[WIDTH-1:0];
                res_we = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                res_lo = (a_neg ^ b_neg) ? ('0 - q_mag) : q_mag;
                res_hi = a_neg ? ('0 - r_mag) : r_mag;
                res_we = (md.rt_val != '0);
            end
            default: begin
                res_we = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                state_q   <= S_RUN;
                cnt_q     <= start_cnt;
                pend_hi_q <= res_hi;
                pend_lo_q <= res_lo;
                pend_we_q <= res_we;
            end else if (md.e_valid && (md.e_md_op == OP_MTHI)) begin
                hi_q <= md.rs_val;
            end else if (md.e_valid && (md.e_md_op == OP_MTLO)) begin
                lo_q <= md.rs_val;
            end
        end else begin
            // Moves and new starts arriving while running are dropped; stall_d keeps them out.
            if (cnt_q == CNT_W'(1)) begin
                if (pend_we_q) begin
                    hi_q <= pend_hi_q;
                    lo_q <= pend_lo_q;
                end
                cnt_q   <= '0;
                state_q <= S_IDLE;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign md.busy     = busy;
    assign md.stall_d  = md.d_is_md && (busy || start);
    assign md.md_rdata = (md.e_md_op == OP_MFHI) ? hi_q :
                         (md.e_md_op == OP_MFLO) ? lo_q : '0;
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;

endmodule
